// File: rtl/ttl_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttl_sync_pkg
// Brief    : Shared strobe-edge selection type and edge-detect helper.
// Revision : 1.0
// ============================================================================
package ttl_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_t;

  function automatic logic edge_hit(input edge_mode_t mode, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttl_strobe_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : ttl_strobe_edge_det
// Brief    : Registers cen and flags the selected edge as a one-cycle strobe.
// Revision : 1.0
// ============================================================================
module ttl_strobe_edge_det
  import ttl_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  edge_mode_t mode,
  output logic       strobe
);

  logic r_cen_q;

  // Reset to 1 so a cen already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cen_q <= 1'b1;
    end else begin
      r_cen_q <= cen;
    end
  end

  assign strobe = edge_hit(mode, cen, r_cen_q);

endmodule
`default_nettype wire

// File: rtl/ttl_reg_chain_sync.sv
`default_nettype none
// ============================================================================
// Module   : ttl_reg_chain_sync
// Brief    : Strobe-captured cascaded register chain with output-control float.
//            Define TTL_REG_CHAIN_TAPS_EN to expose live stage contents on taps.
// Revision : 1.0
// ============================================================================
module ttl_reg_chain_sync
  import ttl_sync_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter edge_mode_t       EDGE_MODE = EDGE_RISE,
  parameter logic [WIDTH-1:0] FLOAT_VAL = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   clr,
  input  logic                   OCn,
  input  logic [WIDTH-1:0]       D,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       valid
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             w_strobe;

  ttl_strobe_edge_det u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .mode   (EDGE_MODE),
    .strobe (w_strobe)
  );

  // Clear takes priority over a coincident strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_valid <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_valid <= '0;
    end else if (w_strobe) begin
      r_stage[0] <= D;
      r_valid[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign Q     = OCn ? FLOAT_VAL : r_stage[DEPTH-1];
  assign valid = r_valid;

`ifdef TTL_REG_CHAIN_TAPS_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
    assign taps[gi*WIDTH +: WIDTH] = r_stage[gi];
  end
`else
  assign taps = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ttl_reg_chain_sync.sv
`default_nettype none
// Directed bench: three chain configurations (rise/depth 2, both/depth 1, rise/depth 3).
module tb_ttl_reg_chain_sync;
  import ttl_sync_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH 8, DEPTH 2, rising edge, FLOAT_VAL 0xFF
  logic       cen_a = 1'b1, clr_a = 1'b0, ocn_a = 1'b0;
  logic [7:0] d_a = 8'h00, q_a;
  logic [15:0] taps_a;
  logic [1:0] valid_a;

  // DUT B: DEPTH 1, both edges
  logic       cen_b = 1'b1, clr_b = 1'b0, ocn_b = 1'b0;
  logic [7:0] d_b = 8'h00, q_b;
  logic [7:0] taps_b;
  logic [0:0] valid_b;

  // DUT C: DEPTH 3, rising edge
  logic       cen_c = 1'b1, clr_c = 1'b0, ocn_c = 1'b0;
  logic [7:0] d_c = 8'h00, q_c;
  logic [23:0] taps_c;
  logic [2:0] valid_c;

  ttl_reg_chain_sync #(.WIDTH(8), .DEPTH(2), .EDGE_MODE(EDGE_RISE), .FLOAT_VAL(8'hFF)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen_a), .clr(clr_a), .OCn(ocn_a),
    .D(d_a), .Q(q_a), .taps(taps_a), .valid(valid_a)
  );

  ttl_reg_chain_sync #(.WIDTH(8), .DEPTH(1), .EDGE_MODE(EDGE_BOTH), .FLOAT_VAL(8'hFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen_b), .clr(clr_b), .OCn(ocn_b),
    .D(d_b), .Q(q_b), .taps(taps_b), .valid(valid_b)
  );

  ttl_reg_chain_sync #(.WIDTH(8), .DEPTH(3), .EDGE_MODE(EDGE_RISE), .FLOAT_VAL(8'hFF)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .cen(cen_c), .clr(clr_c), .OCn(ocn_c),
    .D(d_c), .Q(q_c), .taps(taps_c), .valid(valid_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       cen;
    logic       clr;
    logic       ocn;
    logic [7:0] d;
    logic [7:0] q;
    logic [1:0] v;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Starting state: cen_q=1, all stages 0
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 2'b01};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'h00, 2'b01};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 8'h5A, 2'b11};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h77, 8'h5A, 2'b11};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h77, 8'hFF, 2'b11};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h77, 8'hFF, 2'b11};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 2'b11};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h99, 8'h00, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h99, 8'h00, 2'b00};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h99, 8'h00, 2'b00};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 2'b00};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 2'b00};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 2'b01};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h34, 8'h00, 2'b01};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h34, 8'hFF, 2'b11};

    // Reset values, checked asynchronously while rst_n is low
    #3;
    check("rst_q_oc0", {24'h0, q_a}, 32'h00);
    check("rst_valid", {30'h0, valid_a}, 32'h0);
    ocn_a = 1'b1;
    #1;
    check("rst_q_oc1", {24'h0, q_a}, 32'hFF);
    ocn_a = 1'b0;
    step();
    rst_n = 1'b1;

    // cen held high across reset release: no capture
    repeat (3) step();
    check("cenhigh_q", {24'h0, q_a}, 32'h00);
    check("cenhigh_valid", {30'h0, valid_a}, 32'h0);
    check("cenhigh_valid_c", {29'h0, valid_c}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      cen_a = tbl[i].cen;
      clr_a = tbl[i].clr;
      ocn_a = tbl[i].ocn;
      d_a   = tbl[i].d;
      step();
      check($sformatf("tbl%0d_q", i), {24'h0, q_a}, {24'h0, tbl[i].q});
      check($sformatf("tbl%0d_valid", i), {30'h0, valid_a}, {30'h0, tbl[i].v});
    end
    ocn_a = 1'b0;
    step();
    check("tbl_end_q", {24'h0, q_a}, 32'h12);
    cen_a = 1'b0;

    // Both-edge, depth 1: falling edge after reset captures 0x00
    cen_b = 1'b0; d_b = 8'h00;
    step();
    check("both_fall0_q", {24'h0, q_b}, 32'h00);
    check("both_fall0_valid", {31'h0, valid_b}, 32'h1);
    d_b = 8'h11;
    step();
    check("both_idle_q", {24'h0, q_b}, 32'h00);
    cen_b = 1'b1;
    step();
    check("both_rise_q", {24'h0, q_b}, 32'h11);
    cen_b = 1'b0; d_b = 8'h22;
    step();
    check("both_fall_q", {24'h0, q_b}, 32'h22);
    d_b = 8'h33;
    step();
    check("both_hold_q", {24'h0, q_b}, 32'h22);

    // Depth 3: taps ordering
    cen_c = 1'b0; step();
    d_c = 8'h01; cen_c = 1'b1; step();
    cen_c = 1'b0; step();
    d_c = 8'h02; cen_c = 1'b1; step();
    check("d3_mid_q", {24'h0, q_c}, 32'h00);
    check("d3_mid_valid", {29'h0, valid_c}, 32'h3);
    cen_c = 1'b0; step();
    d_c = 8'h03; cen_c = 1'b1; step();
    check("d3_q", {24'h0, q_c}, 32'h01);
    check("d3_valid", {29'h0, valid_c}, 32'h7);
`ifdef TTL_REG_CHAIN_TAPS_EN
    check("d3_taps", {8'h0, taps_c}, 32'h010203);
`else
    check("d3_taps", {8'h0, taps_c}, 32'h0);
`endif
    cen_c = 1'b0;

    // Mid-sequence reset discards partial data
    d_a = 8'hAB; cen_a = 1'b1; step();
    check("pre_rst_valid", {30'h0, valid_a}, 32'h3);
    rst_n = 1'b0;
    #2;
    check("midrst_q", {24'h0, q_a}, 32'h00);
    check("midrst_valid", {30'h0, valid_a}, 32'h0);
    cen_a = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_q", {24'h0, q_a}, 32'h00);
    d_a = 8'hCD; cen_a = 1'b1; step();
    check("refill1_q", {24'h0, q_a}, 32'h00);
    check("refill1_valid", {30'h0, valid_a}, 32'h1);
    cen_a = 1'b0; step();
    d_a = 8'hEF; cen_a = 1'b1; step();
    check("refill2_q", {24'h0, q_a}, 32'hCD);
    check("refill2_valid", {30'h0, valid_a}, 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ttl_reg_chain_sync.md
TTL_REG_CHAIN_SYNC -- requirements
Module: ttl_reg_chain_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal 1..32.
REQ-002 SHALL have parameter DEPTH, default 2: number of cascaded register stages, legal 1..8.
REQ-003 SHALL have parameter EDGE_MODE, default EDGE_RISE: the strobe edge that captures data; values EDGE_RISE, EDGE_FALL, EDGE_BOTH.
REQ-004 SHALL have parameter FLOAT_VAL, default all-ones: value driven on Q while outputs are disabled.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cen, input, 1 bit: capture strobe, sampled on clk.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of all stages, active-high.
REQ-009 SHALL have port OCn, input, 1 bit: output control, active-low.
REQ-010 SHALL have port D, input, WIDTH bits: data into stage 0.
REQ-011 SHALL have port Q, output, WIDTH bits: contents of stage DEPTH-1, or FLOAT_VAL when OCn=1.
REQ-012 SHALL have port taps, output, WIDTH*DEPTH bits: all stage contents, stage i in bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port valid, output, DEPTH bits: bit i=1 once stage i holds data captured since the last reset or clear.

Function
REQ-014 SHALL register cen each clk into cen_q; cen_q is 1 in reset.
REQ-015 SHALL detect the strobe as follows: EDGE_RISE = cen & ~cen_q; EDGE_FALL = ~cen & cen_q; EDGE_BOTH = cen ^ cen_q.
REQ-016 SHALL, on a strobe cycle, update on the next clk edge: stage0<=D and stage[i]<=stage[i-1] for i>=1.
REQ-017 SHALL make the latency D->Q equal to DEPTH strobes; with DEPTH=1 this is one strobe, i.e. one clk after the detected edge.
REQ-018 SHALL hold all stages unchanged in cycles with no strobe, regardless of D.
REQ-019 SHALL update valid on each strobe with valid[0]<=1 and valid[i]<=valid[i-1].
REQ-020 SHALL, when clr=1, zero all stages and valid on the next edge; clr wins over a simultaneous strobe, and cen_q still updates in that cycle.
REQ-021 SHALL drive Q combinationally from OCn: OCn=1 gives FLOAT_VAL; OCn=0 gives stage[DEPTH-1]; OCn has no effect on stored state.
REQ-022 SHALL NOT capture when cen is held high continuously from reset release, because cen_q resets to 1 (applies to rising-edge detection).

Reset
REQ-023 SHALL, while rst_n=0, asynchronously set all stages and valid to 0 and cen_q to 1.
REQ-024 SHALL output Q = 0 in reset when OCn=0, and FLOAT_VAL when OCn=1.
REQ-025 SHALL, if reset is asserted mid-sequence, discard all partially shifted data; the first strobe after release refills from stage 0.

Configuration
REQ-026 SHALL, when TTL_REG_CHAIN_TAPS_EN is defined, drive taps with live stage contents.
REQ-027 SHALL, when TTL_REG_CHAIN_TAPS_EN is undefined, keep the taps port but drive it constant 0 with no tap logic; Q, valid and the stages are unaffected.

Structure
REQ-028 SHALL define the edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH) in shared package ttl_sync_pkg.
REQ-029 SHALL use sub-module ttl_strobe_edge_det (clk, rst_n, cen, mode -> strobe) for strobe detection; the stage array stays in the top module.

Verification
REQ-030 SHALL verify: WIDTH=8, DEPTH=2, EDGE_RISE, OCn=0; D=0x5A, cen 0->1, then D=0xC3, cen 0->1 -> Q=0x5A after the 2nd strobe, valid=2'b11.
REQ-031 SHALL verify: cen held 1 across reset release -> no capture, valid=0, Q=0x00.
REQ-032 SHALL verify: EDGE_BOTH, DEPTH=1, D=0x11, cen pulse 0->1->0 -> two captures; D changed to 0x22 before the falling edge -> Q=0x22.
REQ-033 SHALL verify: clr=1 in the same cycle as a strobe -> stages=0, valid=0, and the strobe is ignored.
REQ-034 SHALL verify: OCn=1 with FLOAT_VAL=0xFF -> Q=0xFF; strobes during OCn=1 still shift, and Q shows the new data when OCn returns to 0.
REQ-035 SHALL verify: DEPTH=3 with TTL_REG_CHAIN_TAPS_EN defined, strobing 0x01, 0x02, 0x03 -> taps=0x010203 (stage2 in the MS byte); with the macro undefined -> taps=0.
